// File: rtl/pkg.sv
// pkg: shared definitions for the DDS block.
// Sample formats used across the design.
package pkg;
    typedef logic [11:0] sample12_t;
endpackage

// File: rtl/dds_sine_gen_if.sv
// dds_sine_gen_if: configuration handshake and sample bus of dds_sine_gen.
// master is the host side, slave is the generator.
interface dds_sine_gen_if #(
    parameter int OUT_W = 12,
    parameter int ACC_W = 16,
    parameter int NCH   = 2
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [7:0]           cfg_ch;
    logic [ACC_W-1:0]     cfg_ftw;
    logic [ACC_W-1:0]     cfg_phase;
    logic                 cfg_clr;
    logic                 cfg_err;
    logic                 out_valid;
    logic [NCH*OUT_W-1:0] sine;
    logic [NCH-1:0]       out_wrap;

    modport master (
        output cfg_valid, cfg_ch, cfg_ftw, cfg_phase, cfg_clr,
        input  cfg_ready, cfg_err, out_valid, sine, out_wrap
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_ftw, cfg_phase, cfg_clr,
        output cfg_ready, cfg_err, out_valid, sine, out_wrap
    );
endinterface

// File: rtl/dds_sine_gen.sv
// dds_sine_gen: multi-channel DDS with quarter-wave sine table.
// Optional macro DDS_SINE_GEN_AMP_EN adds an 8-bit amplitude scale port.
import pkg::*;

module dds_sine_gen #(
    parameter int OUT_W  = 12,
    parameter int ACC_W  = 16,
    parameter int LUT_AW = 6,
    parameter int NCH    = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
`ifdef DDS_SINE_GEN_AMP_EN
    input  logic [7:0]     amp,
`endif
    dds_sine_gen_if.slave  bus
);
    typedef enum logic {IDLE, APPLY} cfg_state_t;

    localparam longint ONE    = 64'sd1073741824;
    localparam longint PI_Q30 = 64'sd3373259426;
    localparam logic [7:0] NCH8 = 8'(NCH);
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MID_M1 = {1'b0, {(OUT_W-1){1'b1}}};

    // Q30 fixed-point Taylor series, evaluated at elaboration only.
    function automatic logic [OUT_W-2:0] lut_val(input int k);
        longint x, x2, term, s, v;
        x = (PI_Q30 * longint'(2 * k + 1)) / longint'(4 * (2 ** LUT_AW));
        x2 = (x * x) / ONE;
        term = x;
        s = x;
        for (int n = 1; n < 10; n++) begin
            term = -((term * x2) / ONE) / longint'((2 * n) * (2 * n + 1));
            s = s + term;
        end
        v = (s * longint'(2 ** (OUT_W - 1) - 1) + ONE / 2) / ONE;
        return v[OUT_W-2:0];
    endfunction

    logic [OUT_W-2:0] lut [2**LUT_AW];

    for (genvar i = 0; i < 2 ** LUT_AW; i++) begin : g_lut
        localparam logic [OUT_W-2:0] V = lut_val(i);
        assign lut[i] = V;
    end

    cfg_state_t       state, state_nx;
    logic [7:0]       c_ch;
    logic [ACC_W-1:0] c_ftw, c_phase;
    logic             c_clr;
    logic             accept, ch_ok, apply_ok;
    logic             v1, ov;

    assign accept   = bus.cfg_valid && (state == IDLE);
    assign ch_ok    = (c_ch < NCH8);
    assign apply_ok = (state == APPLY) && ch_ok;

    // config FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // config FSM next state and handshake outputs
    always_comb begin
        state_nx      = state;
        bus.cfg_ready = 1'b0;
        bus.cfg_err   = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid) state_nx = APPLY;
            end
            APPLY: begin
                bus.cfg_err = !ch_ok;
                state_nx    = IDLE;
            end
        endcase
    end

    // capture config fields at accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_ch    <= '0;
            c_ftw   <= '0;
            c_phase <= '0;
            c_clr   <= 1'b0;
        end else if (accept) begin
            c_ch    <= bus.cfg_ch;
            c_ftw   <= bus.cfg_ftw;
            c_phase <= bus.cfg_phase;
            c_clr   <= bus.cfg_clr;
        end
    end

    // sample-valid pipeline shared by all channels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            ov <= 1'b0;
        end else begin
            v1 <= enable;
            ov <= v1;
        end
    end

    assign bus.out_valid = ov;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [7:0] CH = 8'(c);
        logic [ACC_W-1:0]  acc, ftw, ph, p;
        logic [ACC_W:0]    sum;
        logic              sel, clr_now, unused_p;
        logic [1:0]        q1;
        logic [LUT_AW-1:0] k1;
        logic              w1, w2;
        logic [OUT_W-2:0]  t, ts;
        logic [OUT_W-1:0]  nxt, smp;

        assign sel      = apply_ok && (c_ch == CH);
        assign clr_now  = sel && c_clr;
        assign sum      = {1'b0, acc} + {1'b0, ftw};
        assign p        = acc + ph;
        assign unused_p = ^p[ACC_W-LUT_AW-3:0];

        // accumulator plus tuning word and phase offset registers
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                acc <= '0;
                ftw <= '0;
                ph  <= '0;
            end else begin
                if (clr_now)     acc <= '0;
                else if (enable) acc <= sum[ACC_W-1:0];
                if (sel) begin
                    ftw <= c_ftw;
                    ph  <= c_phase;
                end
            end
        end

        // stage 1: quadrant, mirrored table address, carry flag
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                q1 <= '0;
                k1 <= '0;
                w1 <= 1'b0;
            end else if (enable) begin
                q1 <= p[ACC_W-1 -: 2];
                k1 <= p[ACC_W-3 -: LUT_AW] ^ {LUT_AW{p[ACC_W-2]}};
                w1 <= sum[ACC_W] && !clr_now;
            end
        end

        assign t = lut[k1];
`ifdef DDS_SINE_GEN_AMP_EN
        logic [OUT_W+6:0] prod;
        assign prod = {8'd0, t} * {{(OUT_W-1){1'b0}}, amp};
        assign ts   = prod[OUT_W+6:8];
`else
        assign ts   = t;
`endif
        assign nxt = q1[1] ? (MID_M1 - {1'b0, ts}) : (MID + {1'b0, ts});

        // stage 2: offset-binary sample, held until a new one arrives
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                smp <= MID;
                w2  <= 1'b0;
            end else if (v1) begin
                smp <= nxt;
                w2  <= w1;
            end
        end

        assign bus.sine[c*OUT_W +: OUT_W] = smp;
        assign bus.out_wrap[c]            = w2;
    end
endmodule

// File: tb/tb_dds_sine_gen.sv
// tb_dds_sine_gen: directed self-checking bench for dds_sine_gen.
// Defaults OUT_W=12, ACC_W=16, LUT_AW=6, NCH=2.
module tb_dds_sine_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
`ifdef DDS_SINE_GEN_AMP_EN
    logic [7:0] amp = 8'hff;
`endif
    int checks = 0;
    int errors = 0;
    int acc0 = 0;
    int acc1 = 0;

    dds_sine_gen_if #(.OUT_W(12), .ACC_W(16), .NCH(2)) bus ();

    dds_sine_gen #(
        .OUT_W(12), .ACC_W(16), .LUT_AW(6), .NCH(2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
`ifdef DDS_SINE_GEN_AMP_EN
        .amp    (amp),
`endif
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // reference table from the real sine function
    function automatic int t_val(int k);
        real a;
        a = 2047.0 * $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / 64.0);
        return $rtoi(a + 0.5);
    endfunction

    function automatic int exp_sine(int p);
        int q, k;
        q = (p >> 14) & 3;
        k = (p >> 8) & 63;
        if (q == 1 || q == 3) k = 63 - k;
        return (q < 2) ? 2048 + t_val(k) : 2047 - t_val(k);
    endfunction

    task automatic do_cfg(input int ch, input int ftw, input int ph, input bit clr);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 8'(ch);
        bus.cfg_ftw   = 16'(ftw);
        bus.cfg_phase = 16'(ph);
        bus.cfg_clr   = clr;
        @(negedge clock);
        bus.cfg_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.sine[11:0] !== 12'd2048) begin
            errors++;
            $display("FAIL reset_lane0: got %0d want 2048", bus.sine[11:0]);
        end
        checks++;
        if (bus.sine[23:12] !== 12'd2048) begin
            errors++;
            $display("FAIL reset_lane1: got %0d want 2048", bus.sine[23:12]);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_wrap !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid_wrap: got %b/%b want 0/00", bus.out_valid, bus.out_wrap);
        end
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg: got ready=%b err=%b want 1/0", bus.cfg_ready, bus.cfg_err);
        end
    endtask

    task automatic test_ch0_wrap();
        int e;
        int wraps;
        wraps = 0;
        do_cfg(0, 'h400, 0, 1'b1);
        acc0 = 0;
        enable = 1'b1;
        for (int j = 1; j <= 129; j++) begin
            @(negedge clock);
            if (j == 1) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ch0_latency: got valid=%b want 0", bus.out_valid);
                end
            end else begin
                e = exp_sine(((j - 2) * 1024) & 'hffff);
                if (j == 2) e = 2073;
                checks++;
                if (bus.out_valid !== 1'b1 || bus.sine[11:0] !== 12'(e)) begin
                    errors++;
                    $display("FAIL ch0_sample n=%0d: got %0d v=%b want %0d v=1",
                             j - 2, bus.sine[11:0], bus.out_valid, e);
                end
                checks++;
                if (bus.out_wrap[0] !== ((j - 2) % 64 == 63)) begin
                    errors++;
                    $display("FAIL ch0_wrap n=%0d: got %b want %b",
                             j - 2, bus.out_wrap[0], ((j - 2) % 64 == 63));
                end
                if (bus.out_wrap[0] === 1'b1) wraps++;
            end
            if (j == 128) enable = 1'b0;
        end
        checks++;
        if (wraps != 2) begin
            errors++;
            $display("FAIL ch0_wrap_count: got %0d want 2", wraps);
        end
        acc0 = 0;
    endtask

    task automatic test_hold();
        for (int j = 0; j < 2; j++) begin
            @(negedge clock);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.sine[11:0] !== 12'(exp_sine('hfc00))
                || bus.out_wrap[0] !== 1'b1) begin
                errors++;
                $display("FAIL hold: got v=%b s=%0d w=%b want v=0 s=%0d w=1",
                         bus.out_valid, bus.sine[11:0], bus.out_wrap[0], exp_sine('hfc00));
            end
        end
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sine[11:0] !== 12'd2073 || bus.out_wrap[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_resume: got v=%b s=%0d w=%b want v=1 s=2073 w=0",
                     bus.out_valid, bus.sine[11:0], bus.out_wrap[0]);
        end
        acc0 = 'h400;
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_valid_fall: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_ch1_phase();
        int e0, e1;
        do_cfg(1, 'h400, 'h4000, 1'b1);
        acc1 = 0;
        enable = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clock);
            if (j >= 2) begin
                e0 = exp_sine((acc0 + (j - 2) * 1024) & 'hffff);
                e1 = exp_sine(('h4000 + acc1 + (j - 2) * 1024) & 'hffff);
                if (j == 2) e1 = 4095;
                checks++;
                if (bus.sine[23:12] !== 12'(e1)) begin
                    errors++;
                    $display("FAIL ch1_sample n=%0d: got %0d want %0d", j - 2, bus.sine[23:12], e1);
                end
                checks++;
                if (bus.sine[11:0] !== 12'(e0)) begin
                    errors++;
                    $display("FAIL ch1_ch0_kept n=%0d: got %0d want %0d", j - 2, bus.sine[11:0], e0);
                end
            end
            if (j == 3) enable = 1'b0;
        end
        acc0 = (acc0 + 3 * 1024) & 'hffff;
        acc1 = (acc1 + 3 * 1024) & 'hffff;
    endtask

    task automatic test_cfg_err();
        int h0, h1;
        h0 = exp_sine((acc0 - 1024) & 'hffff);
        h1 = exp_sine(('h4000 + acc1 - 1024) & 'hffff);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 8'd5;
        bus.cfg_ftw   = 16'h1234;
        bus.cfg_phase = 16'h2222;
        bus.cfg_clr   = 1'b1;
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: got ready=%b err=%b want 1/0", bus.cfg_ready, bus.cfg_err);
        end
        @(negedge clock);
        bus.cfg_valid = 1'b0;
        checks++;
        if (bus.cfg_ready !== 1'b0 || bus.cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL err_pulse: got ready=%b err=%b want 0/1", bus.cfg_ready, bus.cfg_err);
        end
        checks++;
        if (bus.sine[11:0] !== 12'(h0) || bus.sine[23:12] !== 12'(h1)) begin
            errors++;
            $display("FAIL err_held: got %0d/%0d want %0d/%0d",
                     bus.sine[11:0], bus.sine[23:12], h0, h1);
        end
        @(negedge clock);
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_end: got ready=%b err=%b want 1/0", bus.cfg_ready, bus.cfg_err);
        end
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.sine[11:0] !== 12'(exp_sine(acc0))
            || bus.sine[23:12] !== 12'(exp_sine(('h4000 + acc1) & 'hffff))) begin
            errors++;
            $display("FAIL err_no_change: got %0d/%0d want %0d/%0d",
                     bus.sine[11:0], bus.sine[23:12], exp_sine(acc0),
                     exp_sine(('h4000 + acc1) & 'hffff));
        end
        acc0 = (acc0 + 1024) & 'hffff;
        acc1 = (acc1 + 1024) & 'hffff;
        @(negedge clock);
    endtask

    task automatic test_symmetry();
        int s [256];
        int mn, mx;
        do_cfg(0, 'h100, 0, 1'b1);
        enable = 1'b1;
        for (int j = 1; j <= 257; j++) begin
            @(negedge clock);
            if (j >= 2) begin
                s[j-2] = int'(bus.sine[11:0]);
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL sym_valid n=%0d: got %b want 1", j - 2, bus.out_valid);
                end
            end
            if (j == 256) enable = 1'b0;
        end
        checks++;
        if (s[0] != 2073) begin
            errors++;
            $display("FAIL sym_first: got %0d want 2073", s[0]);
        end
        mn = 4096;
        mx = -1;
        for (int n = 0; n < 256; n++) begin
            if (s[n] < mn) mn = s[n];
            if (s[n] > mx) mx = s[n];
            if (n < 128) begin
                checks++;
                if (s[n] + s[n+128] != 4095) begin
                    errors++;
                    $display("FAIL sym_pair n=%0d: got %0d want 4095", n, s[n] + s[n+128]);
                end
            end
        end
        checks++;
        if (mn != 0) begin
            errors++;
            $display("FAIL sym_min: got %0d want 0", mn);
        end
        checks++;
        if (mx != 4095) begin
            errors++;
            $display("FAIL sym_max: got %0d want 4095", mx);
        end
        acc0 = 0;
    endtask

    task automatic test_cfg_during_enable();
        int a, e;
        do_cfg(0, 'h400, 0, 1'b1);
        enable = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clock);
            if (j == 3) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_ch    = 8'd0;
                bus.cfg_ftw   = 16'h0800;
                bus.cfg_phase = 16'h0000;
                bus.cfg_clr   = 1'b0;
            end
            if (j == 4) begin
                bus.cfg_valid = 1'b0;
                checks++;
                if (bus.cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL live_apply_ready: got %b want 0", bus.cfg_ready);
                end
            end
            if (j >= 2) begin
                a = (j - 2 <= 5) ? (j - 2) * 'h400 : 'h1400 + (j - 7) * 'h800;
                e = exp_sine(a & 'hffff);
                checks++;
                if (bus.sine[11:0] !== 12'(e)) begin
                    errors++;
                    $display("FAIL live_ftw m=%0d: got %0d want %0d", j - 2, bus.sine[11:0], e);
                end
            end
            if (j == 10) enable = 1'b0;
        end
    endtask

    task automatic test_reset_midstream();
        enable = 1'b1;
        @(negedge clock);
        @(negedge clock);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 8'd0;
        bus.cfg_ftw   = 16'h1000;
        bus.cfg_phase = 16'h0000;
        bus.cfg_clr   = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.sine !== {12'd2048, 12'd2048} || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out: got %h v=%b want 800800 v=0", bus.sine, bus.out_valid);
        end
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.cfg_err !== 1'b0 || bus.out_wrap !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_cfg: got ready=%b err=%b w=%b want 1/0/00",
                     bus.cfg_ready, bus.cfg_err, bus.out_wrap);
        end
        bus.cfg_valid = 1'b0;
        enable = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release_latency: got %b want 0", bus.out_valid);
        end
        @(negedge clock);
        enable = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sine !== {12'd2073, 12'd2073}) begin
            errors++;
            $display("FAIL mid_first: got %h v=%b want 819819 v=1", bus.sine, bus.out_valid);
        end
        @(negedge clock);
        checks++;
        if (bus.sine[11:0] !== 12'd2073) begin
            errors++;
            $display("FAIL mid_cfg_dropped: got %0d want 2073", bus.sine[11:0]);
        end
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = 8'd0;
        bus.cfg_ftw   = 16'd0;
        bus.cfg_phase = 16'd0;
        bus.cfg_clr   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_ch0_wrap();
        test_hold();
        test_ch1_phase();
        test_cfg_err();
        test_symmetry();
        test_cfg_during_enable();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dds_sine_gen.md
DDS_SINE_GEN -- requirements
Module: dds_sine_gen

Interface
REQ-001 SHALL have parameter OUT_W, default 12, output sample width in bits.
REQ-002 SHALL have parameter ACC_W, default 16, phase accumulator and tuning word width.
REQ-003 SHALL have parameter LUT_AW, default 6, quarter-wave table address bits (2**LUT_AW entries).
REQ-004 SHALL have parameter NCH, default 2, number of independent channels (1..16).
REQ-005 SHALL have port clock  in  1  clock, rising-edge active.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port enable  in  1  advance all accumulators and emit one sample per channel this cycle.
REQ-008 SHALL have port cfg_valid / cfg_ready  in / out  1 / 1  config handshake.
REQ-009 SHALL have port cfg_ch  in  8  target channel index.
REQ-010 SHALL have port cfg_ftw / cfg_phase  in  ACC_W / ACC_W  frequency tuning word / phase offset.
REQ-011 SHALL have port cfg_clr  in  1  clear target accumulator on apply.
REQ-012 SHALL have port cfg_err  out  1  one-cycle pulse: rejected cfg_ch.
REQ-013 SHALL have port out_valid  out  1  sine bus holds new samples.
REQ-014 SHALL have port sine  out  NCH*OUT_W  unsigned offset-binary samples, channel c at bits [c*OUT_W +: OUT_W].
REQ-015 SHALL have port out_wrap  out  NCH  per-channel accumulator-overflow flag, aligned with its sample.

Function
REQ-016 SHALL, per channel on each enable cycle, update acc <= acc + ftw modulo 2**ACC_W; carry-out sets the wrap flag.
REQ-017 SHALL form p = acc + phase (mod 2**ACC_W) from the pre-increment acc, with quadrant q = p[ACC_W-1:ACC_W-2] and index k = p[ACC_W-3 -: LUT_AW].
REQ-018 SHALL use table T[k] = round((2**(OUT_W-1)-1)*sin(pi/2*(k+0.5)/2**LUT_AW)), addressed by k for q=0,2 and by ~k for q=1,3.
REQ-019 SHALL output 2**(OUT_W-1)+T for q=0,1 and 2**(OUT_W-1)-1-T for q=2,3, so the result never over/underflows.
REQ-020 SHALL pipeline in two stages (address/quadrant register, then output register): samples and out_wrap appear with out_valid=1 exactly 2 cycles after the enable cycle.
REQ-021 SHALL, while enable=0, hold accumulators; out_valid falls 2 cycles later, and sine and out_wrap hold their last values.
REQ-022 SHALL implement config FSM IDLE (cfg_ready=1) -> APPLY (cfg_ready=0) on cfg_valid&cfg_ready, then APPLY -> IDLE after exactly 1 cycle; fields are captured at accept.
REQ-023 SHALL, in APPLY, write ftw and phase of cfg_ch; if cfg_clr=1, force acc to 0, overriding any same-cycle increment; other channels are unaffected.
REQ-024 SHALL, for an APPLY coinciding with enable=1 and cfg_clr=0, increment the target acc with the old ftw; the new ftw and phase take effect from the next enable cycle.
REQ-025 SHALL, for cfg_ch >= NCH, still complete the handshake, change no state, and pulse cfg_err during APPLY.

Reset
REQ-026 SHALL, on reset assertion, immediately (asynchronously) set all acc, ftw and phase to 0, FSM to IDLE, cfg_ready=1, cfg_err=0, out_valid=0, out_wrap=0, every sine lane = 2**(OUT_W-1), and pipeline valids to 0.
REQ-027 SHALL discard any in-flight config and pipeline samples when reset is asserted mid-operation; the first valid sample after release comes 2 cycles after the first enable cycle.

Configuration
REQ-028 SHALL, with macro DDS_SINE_GEN_AMP_EN defined, add port amp (in, 8 bits) and replace T by (T*amp)>>8 in stage 2, with latency unchanged; amp=0 gives 2**(OUT_W-1) for q=0,1 and 2**(OUT_W-1)-1 for q=2,3.
REQ-029 SHALL, without DDS_SINE_GEN_AMP_EN, have no amp port and output full-scale T.

Verification (defaults: OUT_W=12, ACC_W=16, LUT_AW=6, NCH=2)
REQ-030 SHALL verify reset: assert reset mid-stream -> sine lanes = 2048, out_valid=0, cfg_ready=1 within the same cycle.
REQ-031 SHALL verify: ch0 ftw=0x0400, phase=0, cfg_clr=1, then enable held -> first ch0 sample 2073 two cycles later; out_wrap[0] every 64 samples.
REQ-032 SHALL verify: ch1 ftw=0x0400, phase=0x4000, cfg_clr=1 -> first ch1 sample 4095; ch0 unaffected.
REQ-033 SHALL verify symmetry: ftw=0x0100 -> over 256 samples, sine[n]+sine[n+128]=4095 for every n, minimum 0, maximum 4095.
REQ-034 SHALL verify cfg_ch=5 -> cfg_err pulses 1 cycle, cfg_ready low 1 cycle, no output change.
REQ-035 SHALL verify config during enable=1 with ftw change 0x0400->0x0800 -> one more step of 0x0400, then steps of 0x0800.
